// File: rtl/mem_channel_arbiter_if.sv
// Request/response bundle for a set of memory lanes: consumer lanes on one side
// of the arbiter, memory channels on the other.
interface mem_channel_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LANES     = 1
);
    // Handshake: the master raises *_valid with address/data and holds them
    // until it sees *_ready. A memory channel answers with a single-cycle
    // ready (read_data valid in that cycle). A consumer-facing ready stays
    // high, with read_data stable, until the consumer drops its valid.
    logic [LANES-1:0]                read_valid;
    logic [LANES-1:0][ADDR_BITS-1:0] read_address;
    logic [LANES-1:0]                read_ready;
    logic [LANES-1:0][DATA_BITS-1:0] read_data;
    logic [LANES-1:0]                write_valid;
    logic [LANES-1:0][ADDR_BITS-1:0] write_address;
    logic [LANES-1:0][DATA_BITS-1:0] write_data;
    logic [LANES-1:0]                write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin sharing of NUM_CHANNELS memory channels among NUM_CONSUMERS requesters.
// Optional perf counters are built when MEM_ARB_PERF_COUNTERS_EN is defined.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1,
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    mem_channel_arbiter_if.slave          consumer,
    mem_channel_arbiter_if.master         mem,
`ifdef MEM_ARB_PERF_COUNTERS_EN
    output logic [NUM_CHANNELS-1:0][15:0] perf_grant_count,
    output logic [15:0]                   perf_stall_cycles,
`endif
    output logic [NUM_CHANNELS-1:0][2:0]  dbg_state,
    output logic [CW-1:0]                 dbg_rr_ptr
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    chan_state_t state_q [NUM_CHANNELS];
    chan_state_t state_d [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0]                claim_q, rd_rdy_q, wr_rdy_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q;
    logic [NUM_CHANNELS-1:0][CW-1:0]         sel_q;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  addr_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  wdata_q;
    logic [CW-1:0]                           rr_q, rr_d;

    logic [NUM_CONSUMERS-1:0]        wr_req, pending, taken;
    logic [NUM_CHANNELS-1:0]         grant, grant_rd;
    logic [NUM_CHANNELS-1:0][CW-1:0] grant_idx;

    assign wr_req  = (WRITE_ENABLE != 0) ? consumer.write_valid : '0;
    assign pending = (consumer.read_valid | wr_req) & ~claim_q & ~(rd_rdy_q | wr_rdy_q);

    // Each idle channel takes the first untaken pending consumer from the pointer on;
    // the last grant of the cycle is the furthest from the pointer, so it moves rr.
    always_comb begin
        int sum;
        logic [CW-1:0] cand;
        sum       = 0;
        cand      = '0;
        taken     = '0;
        grant     = '0;
        grant_rd  = '0;
        grant_idx = '0;
        rr_d      = rr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    sum = int'(rr_q) + k;
                    if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
                    cand = CW'(sum);
                    if (!grant[c] && pending[cand] && !taken[cand]) begin
                        grant[c]     = 1'b1;
                        grant_idx[c] = cand;
                        grant_rd[c]  = consumer.read_valid[cand];
                        taken[cand]  = 1'b1;
                        rr_d         = (sum == NUM_CONSUMERS - 1) ? '0 : CW'(sum + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                IDLE:        if (grant[c]) state_d[c] = grant_rd[c] ? READ_WAIT : WRITE_WAIT;
                READ_WAIT:   if (mem.read_ready[c]) state_d[c] = READ_RELAY;
                WRITE_WAIT:  if (mem.write_ready[c]) state_d[c] = WRITE_RELAY;
                READ_RELAY:  if (!consumer.read_valid[sel_q[c]]) state_d[c] = IDLE;
                WRITE_RELAY: if (!consumer.write_valid[sel_q[c]]) state_d[c] = IDLE;
                default:     state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) state_q[c] <= IDLE;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) state_q[c] <= state_d[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claim_q   <= '0;
            rd_rdy_q  <= '0;
            wr_rdy_q  <= '0;
            rd_data_q <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rr_q      <= '0;
        end else begin
            rr_q <= rr_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    IDLE: if (grant[c]) begin
                        sel_q[c]              <= grant_idx[c];
                        claim_q[grant_idx[c]] <= 1'b1;
                        addr_q[c]             <= grant_rd[c] ? consumer.read_address[grant_idx[c]]
                                                             : consumer.write_address[grant_idx[c]];
                        wdata_q[c]            <= consumer.write_data[grant_idx[c]];
                    end
                    READ_WAIT: if (mem.read_ready[c]) begin
                        rd_data_q[sel_q[c]] <= mem.read_data[c];
                        rd_rdy_q[sel_q[c]]  <= 1'b1;
                    end
                    WRITE_WAIT: if (mem.write_ready[c]) wr_rdy_q[sel_q[c]] <= 1'b1;
                    READ_RELAY: if (!consumer.read_valid[sel_q[c]]) begin
                        rd_rdy_q[sel_q[c]] <= 1'b0;
                        claim_q[sel_q[c]]  <= 1'b0;
                    end
                    WRITE_RELAY: if (!consumer.write_valid[sel_q[c]]) begin
                        wr_rdy_q[sel_q[c]] <= 1'b0;
                        claim_q[sel_q[c]]  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel request lines are zero outside their WAIT state.
    always_comb begin
        mem.read_valid    = '0;
        mem.read_address  = '0;
        mem.write_valid   = '0;
        mem.write_address = '0;
        mem.write_data    = '0;
        dbg_state         = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            dbg_state[c] = state_q[c];
            if (state_q[c] == READ_WAIT) begin
                mem.read_valid[c]   = 1'b1;
                mem.read_address[c] = addr_q[c];
            end
            if (WRITE_ENABLE != 0 && state_q[c] == WRITE_WAIT) begin
                mem.write_valid[c]   = 1'b1;
                mem.write_address[c] = addr_q[c];
                mem.write_data[c]    = wdata_q[c];
            end
        end
    end

    assign consumer.read_ready  = rd_rdy_q;
    assign consumer.read_data   = rd_data_q;
    assign consumer.write_ready = (WRITE_ENABLE != 0) ? wr_rdy_q : '0;
    assign dbg_rr_ptr           = rr_q;

`ifdef MEM_ARB_PERF_COUNTERS_EN
    logic any_idle;

    always_comb begin
        any_idle = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == IDLE) any_idle = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grant_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (grant[c] && perf_grant_count[c] != 16'hFFFF)
                    perf_grant_count[c] <= perf_grant_count[c] + 16'd1;
            end
            if (|pending && !any_idle && perf_stall_cycles != 16'hFFFF)
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: a 4x2 read/write instance and a 4x1 read-only instance.
module tb_mem_channel_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .LANES(4)) ca ();
    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .LANES(2)) ma ();
    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .LANES(4)) cb ();
    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .LANES(1)) mb ();

    logic [1:0][2:0] dbg_state_a;
    logic [1:0]      dbg_rr_a;
    logic [0:0][2:0] dbg_state_b;
    logic [1:0]      dbg_rr_b;
`ifdef MEM_ARB_PERF_COUNTERS_EN
    logic [1:0][15:0] perf_grant_a;
    logic [15:0]      perf_stall_a;
    logic [0:0][15:0] perf_grant_b;
    logic [15:0]      perf_stall_b;
`endif

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                          .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .consumer(ca), .mem(ma),
`ifdef MEM_ARB_PERF_COUNTERS_EN
        .perf_grant_count(perf_grant_a), .perf_stall_cycles(perf_stall_a),
`endif
        .dbg_state(dbg_state_a), .dbg_rr_ptr(dbg_rr_a)
    );

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                          .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
        .clk(clk), .reset(reset), .consumer(cb), .mem(mb),
`ifdef MEM_ARB_PERF_COUNTERS_EN
        .perf_grant_count(perf_grant_b), .perf_stall_cycles(perf_stall_b),
`endif
        .dbg_state(dbg_state_b), .dbg_rr_ptr(dbg_rr_b)
    );

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;
    logic [11:0] exp_q[$];
    logic [11:0] exp_b_q[$];
    logic [15:0] wr_log[$];
    int order_b[$];
    int rdy_cnt[4] = '{default: 0};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel, input int c);
        return (sel == 0) ? ca.read_ready[c] : cb.read_ready[c];
    endfunction

    // Memory model: read data is address ^ 0x46, ready pulses after mem_lat cycles.
    initial begin : mem_model
        int rcnt[2];
        int wcnt[2];
        int bcnt;
        rcnt = '{0, 0};
        wcnt = '{0, 0};
        bcnt = 0;
        ma.read_ready = '0; ma.read_data = '0; ma.write_ready = '0;
        mb.read_ready = '0; mb.read_data = '0; mb.write_ready = '0;
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < 2; ch++) begin
                if (!reset || ma.read_ready[ch]) begin
                    ma.read_ready[ch] = 1'b0; rcnt[ch] = 0;
                end else if (ma.read_valid[ch]) begin
                    rcnt[ch]++;
                    if (rcnt[ch] >= mem_lat) begin
                        ma.read_ready[ch] = 1'b1;
                        ma.read_data[ch]  = ma.read_address[ch] ^ 8'h46;
                        rcnt[ch] = 0;
                    end
                end
                if (!reset || ma.write_ready[ch]) begin
                    ma.write_ready[ch] = 1'b0; wcnt[ch] = 0;
                end else if (ma.write_valid[ch]) begin
                    wcnt[ch]++;
                    if (wcnt[ch] >= mem_lat) begin
                        ma.write_ready[ch] = 1'b1;
                        wr_log.push_back({ma.write_address[ch], ma.write_data[ch]});
                        wcnt[ch] = 0;
                    end
                end
            end
            if (!reset || mb.read_ready[0]) begin
                mb.read_ready[0] = 1'b0; bcnt = 0;
            end else if (mb.read_valid[0]) begin
                bcnt++;
                if (bcnt >= mem_lat) begin
                    mb.read_ready[0] = 1'b1;
                    mb.read_data[0]  = mb.read_address[0] ^ 8'h46;
                    bcnt = 0;
                end
            end
        end
    end

    // Scoreboard: each rising consumer read_ready pops that consumer's oldest expected entry.
    initial begin : monitor
        logic [3:0] prev_a, prev_b;
        bit found;
        prev_a = '0;
        prev_b = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ca.read_ready[i] && !prev_a[i]) begin
                    rdy_cnt[i]++;
                    found = 1'b0;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (!found && exp_q[j][11:8] == 4'(i)) begin
                            check("a_rd_data", 32'(ca.read_data[i]), 32'(exp_q[j][7:0]));
                            exp_q.delete(j);
                            found = 1'b1;
                        end
                    end
                    check("a_rd_expected", 32'(found), 1);
                end
                if (cb.read_ready[i] && !prev_b[i]) begin
                    order_b.push_back(i);
                    found = 1'b0;
                    for (int j = 0; j < exp_b_q.size(); j++) begin
                        if (!found && exp_b_q[j][11:8] == 4'(i)) begin
                            check("b_rd_data", 32'(cb.read_data[i]), 32'(exp_b_q[j][7:0]));
                            exp_b_q.delete(j);
                            found = 1'b1;
                        end
                    end
                    check("b_rd_expected", 32'(found), 1);
                end
            end
            prev_a = ca.read_ready;
            prev_b = cb.read_ready;
        end
    end

    task automatic rd_req(input int sel, input int c, input logic [7:0] a);
        int n;
        if (sel == 0) begin
            ca.read_address[c] = a;
            ca.read_valid[c]   = 1'b1;
            exp_q.push_back({4'(c), a ^ 8'h46});
        end else begin
            cb.read_address[c] = a;
            cb.read_valid[c]   = 1'b1;
            exp_b_q.push_back({4'(c), a ^ 8'h46});
        end
        n = 0;
        while (!rdy(sel, c) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_ready", 32'(rdy(sel, c)), 1);
        if (sel == 0) ca.read_valid[c] = 1'b0;
        else cb.read_valid[c] = 1'b0;
        @(posedge clk); #1;
        check("rd_release", 32'(rdy(sel, c)), 0);
    endtask

    task automatic pop_write(input logic [7:0] a, input logic [7:0] d);
        logic [15:0] e;
        check("wr_log_n", wr_log.size(), 1);
        if (wr_log.size() > 0) begin
            e = wr_log.pop_front();
            check("wr_addr", 32'(e[15:8]), 32'(a));
            check("wr_data", 32'(e[7:0]), 32'(d));
        end
    endtask

    task automatic wait_wr_ready(input int c);
        int n;
        n = 0;
        while (!ca.write_ready[c] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wr_ready", 32'(ca.write_ready[c]), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base[4];
        int exp_order[4];
        int ro_seen;
        int n;
        exp_order = '{0, 3, 0, 3};
        reset = 1'b0;
        ca.read_valid = '0; ca.read_address = '0; ca.write_valid = '0;
        ca.write_address = '0; ca.write_data = '0;
        cb.read_valid = '0; cb.read_address = '0; cb.write_valid = '0;
        cb.write_address = '0; cb.write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rv", 32'(ma.read_valid), 0);
        check("rst_mem_wv", 32'(ma.write_valid), 0);
        check("rst_cons_rdy", 32'(ca.read_ready), 0);
        check("rst_state", 32'(dbg_state_a), 0);
        check("rst_rr", 32'(dbg_rr_a), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Contention: four reads at once on two channels, 1-cycle memory.
        mem_lat = 1;
        for (int i = 0; i < 4; i++) base[i] = rdy_cnt[i];
        fork
            rd_req(0, 0, 8'h21);
            rd_req(0, 1, 8'h32);
            rd_req(0, 2, 8'h43);
            rd_req(0, 3, 8'h54);
            begin
                @(posedge clk); #2;
                check("c_ch0_addr", 32'(ma.read_address[0]), 'h21);
                check("c_ch1_addr", 32'(ma.read_address[1]), 'h32);
                check("c_rr_mid", 32'(dbg_rr_a), 2);
            end
        join
        @(negedge clk);
        check("c_rr_end", 32'(dbg_rr_a), 0);
        for (int i = 0; i < 4; i++) check("c_once", rdy_cnt[i] - base[i], 1);
        @(posedge clk); #1;

        // Single read, 2-cycle memory.
        mem_lat = 2;
        fork
            rd_req(0, 2, 8'h1A);
            begin
                @(posedge clk); #2;
                check("t1_mvalid", 32'(ma.read_valid[0]), 1);
                check("t1_maddr", 32'(ma.read_address[0]), 'h1A);
                check("t1_ch1_idle", 32'(ma.read_valid[1]), 0);
            end
        join

        // Write path with ready held for three cycles.
        mem_lat = 1;
        ca.write_address[1] = 8'h40;
        ca.write_data[1]    = 8'h77;
        ca.write_valid[1]   = 1'b1;
        @(posedge clk); #1;
        check("w_mvalid", 32'(ma.write_valid[0]), 1);
        check("w_maddr", 32'(ma.write_address[0]), 'h40);
        check("w_mdata", 32'(ma.write_data[0]), 'h77);
        wait_wr_ready(1);
        repeat (3) begin
            @(posedge clk); #1;
            check("w_hold", 32'(ca.write_ready[1]), 1);
        end
        ca.write_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("w_release", 32'(ca.write_ready[1]), 0);
        pop_write(8'h40, 8'h77);

        // Read and write together on one consumer: read first.
        mem_lat = 2;
        ca.read_address[3]  = 8'h10;
        ca.write_address[3] = 8'h20;
        ca.write_data[3]    = 8'h99;
        exp_q.push_back({4'd3, 8'h10 ^ 8'h46});
        ca.read_valid[3]  = 1'b1;
        ca.write_valid[3] = 1'b1;
        @(posedge clk); #1;
        check("rw_read_first", 32'(ma.read_valid), 1);
        check("rw_no_write", 32'(ma.write_valid), 0);
        n = 0;
        while (!ca.read_ready[3] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rw_rd_ready", 32'(ca.read_ready[3]), 1);
        check("rw_wr_not_yet", wr_log.size(), 0);
        ca.read_valid[3] = 1'b0;
        @(posedge clk); #1;
        check("rw_rd_release", 32'(ca.read_ready[3]), 0);
        check("rw_wr_after_relay", 32'(ma.write_valid), 0);
        wait_wr_ready(3);
        ca.write_valid[3] = 1'b0;
        @(posedge clk); #1;
        check("rw_wr_release", 32'(ca.write_ready[3]), 0);
        pop_write(8'h20, 8'h99);

        // Fairness on the single-channel instance.
        mem_lat = 1;
        fork
            begin rd_req(1, 0, 8'h05); rd_req(1, 0, 8'h06); end
            begin rd_req(1, 3, 8'h07); rd_req(1, 3, 8'h08); end
        join
        @(negedge clk);
        check("fair_n", order_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < order_b.size()) check("fair_order", order_b[i], exp_order[i]);
        end
        @(posedge clk); #1;

        // Read-only instance ignores writes.
        cb.write_address[1] = 8'h40;
        cb.write_data[1]    = 8'h77;
        cb.write_valid[1]   = 1'b1;
        ro_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mb.write_valid != '0 || cb.write_ready != '0 || mb.write_address != '0) ro_seen++;
        end
        check("ro_no_write", ro_seen, 0);
        check("ro_state_idle", 32'(dbg_state_b), 0);
        cb.write_valid[1] = 1'b0;

        // Reset during READ_WAIT.
        mem_lat = 20;
        ca.read_address[0] = 8'h66;
        ca.read_valid[0]   = 1'b1;
        @(posedge clk); #1;
        check("rst_pre_valid", 32'(ma.read_valid[0]), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_mid_rv", 32'(ma.read_valid), 0);
        check("rst_mid_addr", 32'(ma.read_address[0]), 0);
        check("rst_mid_state", 32'(dbg_state_a), 0);
        check("rst_mid_rr", 32'(dbg_rr_a), 0);
        check("rst_mid_rdy", 32'(ca.read_ready), 0);
        ca.read_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_lat = 1;
        @(posedge clk); #1;
        fork
            rd_req(0, 2, 8'h3B);
            begin
                @(posedge clk); #2;
                check("post_ch0", 32'(ma.read_valid[0]), 1);
                check("post_ch0_addr", 32'(ma.read_address[0]), 'h3B);
                check("post_rr", 32'(dbg_rr_a), 3);
            end
        join

        repeat (2) @(posedge clk);
        #1;
        check("sb_a_empty", exp_q.size(), 0);
        check("sb_b_empty", exp_b_q.size(), 0);
        check("wr_log_empty", wr_log.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares NUM_CHANNELS external memory channels among NUM_CONSUMERS requesters, either LSUs on the data side or fetchers on the program side.
- Each channel runs its own transaction FSM.
- Idle channels are handed to pending consumers in round-robin order, so no requester starves.
- Sits between the per-core LSU/fetcher arrays and the top-level memory ports.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- NUM_CONSUMERS, 8, number of requesters (>=1)
- NUM_CHANNELS, 2, number of memory channels (1..NUM_CONSUMERS)
- WRITE_ENABLE, 1, 0 = read-only instance: write inputs ignored, write outputs tied 0

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- consumer_read_valid  in  NUM_CONSUMERS  read request per consumer
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read address
- consumer_read_ready  out  NUM_CONSUMERS  read data valid / ack
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  read data
- consumer_write_valid  in  NUM_CONSUMERS  write request
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write ack
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  NUM_CHANNELS x ADDR_BITS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read complete
- mem_read_data  in  NUM_CHANNELS x DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  NUM_CHANNELS x ADDR_BITS  channel write address
- mem_write_data  out  NUM_CHANNELS x DATA_BITS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write complete

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; every channel FSM goes to IDLE.
  - Claim mask cleared; RR pointer = 0.
  - Applies mid-transaction too: an in-flight request is dropped silently.
- Channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- A consumer is pending when its read_valid or write_valid is 1, it is unclaimed, and its ready output is 0.
- IDLE: the channel selects the first pending consumer at or after the RR pointer (modulo NUM_CONSUMERS), skipping consumers already chosen by lower-index channels in the same cycle.
  - On selection, the channel claims the consumer and registers its address (and data for writes).
  - The channel moves to READ_WAIT if read_valid=1, else WRITE_WAIT.
  - If a consumer asserts both read_valid and write_valid, read wins; the write is serviced in a later grant.
- Channels are scanned in ascending index within one cycle. At most one channel per consumer; at most one consumer per channel.
- RR pointer after any grant cycle = (highest-ordered granted consumer index + 1) mod NUM_CONSUMERS. Unchanged if no grant.
- READ_WAIT: mem_read_valid=1 with the held address.
  - When mem_read_ready=1: drop mem_read_valid, register mem_read_data into consumer_read_data, set consumer_read_ready=1, go to READ_RELAY.
- WRITE_WAIT: mem_write_valid=1 with the held address and data.
  - When mem_write_ready=1: drop mem_write_valid, set consumer_write_ready=1, go to WRITE_RELAY.
- RELAY states: hold ready=1 (and read data stable) until the consumer deasserts its corresponding valid.
  - Then drop ready, release the claim, and return to IDLE the next cycle.
  - A new grant is possible from that IDLE cycle.
- Latency:
  - Request seen at edge N -> mem_*_valid high after edge N+1.
  - mem ready seen at edge M -> consumer ready high after edge M+1.
  - Minimum round trip is 3 cycles plus memory latency.
- Address, data and valid are sampled only at grant; consumer changes after grant are ignored until release.
- Consumer valid dropped while its channel is in WAIT: the transaction still completes. Ready pulses for 1 cycle, then the channel returns to IDLE.
- More pending consumers than free channels: the excess wait. Bounded wait is at most ceil(NUM_CONSUMERS/NUM_CHANNELS) transactions.
- WRITE_ENABLE=0: write_valid is never pending; consumer_write_ready and all mem_write_* are constant 0.

Optional Feature:
- Macro: MEM_ARB_PERF_COUNTERS_EN.
- Defined: adds output perf_grant_count (NUM_CHANNELS x 16).
  - Each channel counter increments on every grant, saturating at 16'hFFFF.
  - Adds output perf_stall_cycles (16), which increments each cycle with >=1 pending consumer and no idle channel, also saturating.
  - Both cleared by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single read, 4 consumers/2 channels: consumer 2 reads addr 0x1A, memory returns 0x5C after 2 cycles -> mem_read_valid[0]=1 addr 0x1A; consumer_read_ready[2]=1 with data 0x5C; ready drops the cycle after read_valid drops.
- Contention: consumers 0-3 request reads in the same cycle, 1-cycle memory -> grants go to 0,1 on channels 0,1, then 2,3; pointer ends at 0; every consumer gets ready exactly once.
- Fairness: consumer 0 re-requests immediately each time, 1 channel, consumers 0 and 3 pending -> grant order 0,3,0,3.
- Write path: consumer 1 writes 0x77 to 0x40 -> mem_write_valid=1 with addr 0x40, data 0x77; consumer_write_ready[1] high until write_valid drops. With WRITE_ENABLE=0 the same stimulus gives no mem_write_valid.
- Read+write same consumer: read 0x10 and write 0x20 together -> read serviced first; write granted only after the read relay completes.
- Reset mid-op: assert reset during READ_WAIT -> all outputs 0 asynchronously; after release, a new request is granted on channel 0 with pointer 0.
